// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer and its 1-bit slice.
package alu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCmp,
        StDone
    } alu_state_e;

    localparam logic [1:0] OpAnd = 2'd0;
    localparam logic [1:0] OpOr  = 2'd1;
    localparam logic [1:0] OpAdd = 2'd2;
    localparam logic [1:0] OpCmp = 2'd3;

    localparam logic [2:0] BonusSlt  = 3'd0;
    localparam logic [2:0] BonusSgt  = 3'd1;
    localparam logic [2:0] BonusSle  = 3'd2;
    localparam logic [2:0] BonusSge  = 3'd3;
    localparam logic [2:0] BonusSeq  = 3'd4;
    localparam logic [2:0] BonusSne  = 3'd5;
    localparam logic [2:0] BonusRsvd = 3'd6;
    localparam logic [2:0] BonusZero = 3'd7;

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice: AND/OR/full-add/compare-select on one bit position.
module alu_slice
    import alu_pkg::*;
(
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       equal,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    input  logic [2:0] bonus_op,
    output logic       result,
    output logic       cout
);

    logic a, b, cmp;

    always_comb begin
        a    = src1 ^ A_invert;
        b    = src2 ^ B_invert;
        cout = (a & b) | (a & cin) | (b & cin);

        case (bonus_op)
            BonusSlt: cmp = less;
            BonusSgt: cmp = ~(less | equal);
            BonusSle: cmp = less | equal;
            BonusSge: cmp = ~less;
            BonusSeq: cmp = equal;
            BonusSne: cmp = ~equal;
            default:  cmp = 1'b0;
        endcase

        unique case (operation)
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpAdd:   result = a ^ b ^ cin;
            default: result = cmp;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, one bit per clock.
// Optional completed-result counter output op_cnt under ALU_SERIAL_CYCLE_CNT_EN.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    input  logic [2:0]       bonus_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             sl_src1,
    output logic             sl_src2,
    output logic             sl_less,
    output logic             sl_equal,
    output logic             sl_A_invert,
    output logic             sl_B_invert,
    output logic             sl_cin,
    output logic [1:0]       sl_operation,
    output logic [2:0]       sl_bonus_op,
    input  logic             sl_result,
    input  logic             sl_cout
`ifdef ALU_SERIAL_CYCLE_CNT_EN
    ,
    output logic [31:0]      op_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [2:0]       bonus_q, bonus_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [1:0]       op_q;
    logic             cmp_less, cmp_equal;

    assign op_q      = ctrl_q[1:0];
    // carry_q holds the MSB carry-out once the subtraction pass has finished
    assign cmp_equal = (result_q == '0);
    assign cmp_less  = result_q[WIDTH-1] ^ (cin_msb_q ^ carry_q);

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    // Slice inputs depend only on registered state, so the external slice loop stays acyclic.
    always_comb begin
        sl_src1      = 1'b0;
        sl_src2      = 1'b0;
        sl_less      = 1'b0;
        sl_equal     = 1'b0;
        sl_A_invert  = 1'b0;
        sl_B_invert  = 1'b0;
        sl_cin       = 1'b0;
        sl_operation = 2'd0;
        sl_bonus_op  = 3'd0;
        unique case (state_q)
            StRun: begin
                sl_src1      = a_q[idx_q];
                sl_src2      = b_q[idx_q];
                sl_A_invert  = ctrl_q[3];
                sl_B_invert  = ctrl_q[2];
                sl_operation = (op_q == OpCmp) ? OpAdd : op_q;
                sl_cin       = (idx_q == '0) ? (op_q[1] & ctrl_q[2]) : carry_q;
            end
            StCmp: begin
                sl_operation = OpCmp;
                sl_less      = cmp_less;
                sl_equal     = cmp_equal;
                sl_bonus_op  = (bonus_q == BonusRsvd) ? BonusZero : bonus_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        bonus_d   = bonus_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        result_d  = result_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = src1;
                    b_d      = src2;
                    ctrl_d   = alu_ctrl;
                    bonus_d  = bonus_op;
                    result_d = '0;
                    carry_d  = 1'b0;
                    idx_d    = '0;
                    zero_d   = 1'b0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                result_d[idx_q] = sl_result;
                carry_d         = sl_cout;
                idx_d           = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cin_msb_d = sl_cin;
                    idx_d     = '0;
                    if (op_q == OpCmp) begin
                        state_d = StCmp;
                    end else begin
                        zero_d  = (result_d == '0);
                        cout_d  = (op_q == OpAdd) & sl_cout;
                        ovf_d   = (op_q == OpAdd) & (sl_cin ^ sl_cout);
                        state_d = StDone;
                    end
                end
            end
            StCmp: begin
                result_d = {{(WIDTH-1){1'b0}}, sl_result};
                zero_d   = ~sl_result;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            bonus_q   <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            bonus_q   <= bonus_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef ALU_SERIAL_CYCLE_CNT_EN
    logic [31:0] op_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            op_cnt_q <= op_cnt_q + 32'd1;
        end
    end

    assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench: alu_serial_ctrl paired with alu_slice, checked against an arithmetic model.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] src1, src2, result;
    logic [3:0]   alu_ctrl;
    logic [2:0]   bonus_op;
    logic         zero, cout, overflow;
    logic         sl_src1, sl_src2, sl_less, sl_equal, sl_A_invert, sl_B_invert, sl_cin;
    logic [1:0]   sl_operation;
    logic [2:0]   sl_bonus_op;
    logic         sl_result, sl_cout;
`ifdef ALU_SERIAL_CYCLE_CNT_EN
    logic [31:0]  op_cnt;
    int unsigned  exp_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .src1         (src1),
        .src2         (src2),
        .alu_ctrl     (alu_ctrl),
        .bonus_op     (bonus_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .cout         (cout),
        .overflow     (overflow),
        .sl_src1      (sl_src1),
        .sl_src2      (sl_src2),
        .sl_less      (sl_less),
        .sl_equal     (sl_equal),
        .sl_A_invert  (sl_A_invert),
        .sl_B_invert  (sl_B_invert),
        .sl_cin       (sl_cin),
        .sl_operation (sl_operation),
        .sl_bonus_op  (sl_bonus_op),
        .sl_result    (sl_result),
        .sl_cout      (sl_cout)
`ifdef ALU_SERIAL_CYCLE_CNT_EN
        ,
        .op_cnt       (op_cnt)
`endif
    );

    alu_slice u_slice (
        .src1      (sl_src1),
        .src2      (sl_src2),
        .less      (sl_less),
        .equal     (sl_equal),
        .A_invert  (sl_A_invert),
        .B_invert  (sl_B_invert),
        .cin       (sl_cin),
        .operation (sl_operation),
        .bonus_op  (sl_bonus_op),
        .result    (sl_result),
        .cout      (sl_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what each named operation means arithmetically.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] ctrl, input logic [2:0] bop,
                                  output logic [W-1:0] r, output logic z, output logic c,
                                  output logic v, output int lat);
        logic [W:0] s;
        logic       lt, eq, bit_r;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        lat = W + 1;
        case (ctrl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: begin
                lt = ($signed(a) < $signed(b));
                eq = (a == b);
                case (bop)
                    3'd0:    bit_r = lt;
                    3'd1:    bit_r = !lt && !eq;
                    3'd2:    bit_r = lt || eq;
                    3'd3:    bit_r = !lt;
                    3'd4:    bit_r = eq;
                    3'd5:    bit_r = !eq;
                    default: bit_r = 1'b0;
                endcase
                r   = W'(bit_r);
                lat = W + 2;
            end
            default: r = '0;
        endcase
        z = (r == '0);
    endfunction

    // Called just after a rising edge with the DUT idle; hold = cycles to stall out_ready.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] ctrl, input logic [2:0] bop, input int hold);
        logic [W-1:0] er;
        logic         ez, ec, eo;
        int           el, lat;
        model(a, b, ctrl, bop, er, ez, ec, eo, el);
        out_ready = (hold == 0);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
        src1 = a;
        src2 = b;
        alu_ctrl = ctrl;
        bonus_op = bop;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1 = W'($urandom);
        src2 = W'($urandom);
        alu_ctrl = 4'($urandom);
        bonus_op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(el));
        check({tag, ".result"}, 64'(result), 64'(er));
        check({tag, ".zero"}, 64'(zero), 64'(ez));
        check({tag, ".cout"}, 64'(cout), 64'(ec));
        check({tag, ".overflow"}, 64'(overflow), 64'(eo));
        check({tag, ".in_ready_done"}, 64'(in_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, ".hold_result"}, 64'(result), 64'(er));
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".valid_drop"}, 64'(out_valid), 64'(0));
        check({tag, ".back_idle"}, 64'(in_ready), 64'(1));
`ifdef ALU_SERIAL_CYCLE_CNT_EN
        exp_cnt++;
        check({tag, ".op_cnt"}, 64'(op_cnt), 64'(exp_cnt));
`endif
    endtask

    logic [3:0] ctrl_tbl [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101, 4'b0111};

    initial begin
        logic [W-1:0] ra, rb;
        int           seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        src1 = '0;
        src2 = '0;
        alu_ctrl = '0;
        bonus_op = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 64'(in_ready), 64'(1));
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.result", 64'(result), 64'(0));
        check("reset.flags", 64'({zero, cout, overflow}), 64'(0));
        check("reset.slice", 64'({sl_src1, sl_src2, sl_less, sl_equal, sl_A_invert, sl_B_invert,
                                  sl_cin, sl_operation, sl_bonus_op}), 64'(0));
`ifdef ALU_SERIAL_CYCLE_CNT_EN
        check("reset.op_cnt", 64'(op_cnt), 64'(0));
`endif
        rst = 1'b0;

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 3'd0, 0);
        run_op("sub_eq", 32'd5, 32'd5, 4'b0110, 3'd0, 0);
        run_op("slt", 32'hFFFF_FFFE, 32'd3, 4'b0111, 3'd0, 0);
        run_op("sgt", 32'hFFFF_FFFE, 32'd3, 4'b0111, 3'd1, 0);
        run_op("rsvd6", 32'd1, 32'd9, 4'b0111, 3'd6, 0);
        run_op("nor", 32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100, 3'd0, 0);
        run_op("or", 32'h0F0F_0F0F, 32'h00FF_00FF, 4'b0001, 3'd0, 0);
        run_op("stall", 32'h1234_5678, 32'h0FED_CBA9, 4'b0010, 3'd0, 5);
        run_op("back2back", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 3'd0, 0);

        // Abort mid-RUN with idx at 10
        src1 = 32'h0000_00FF;
        src2 = 32'h0000_0F00;
        alu_ctrl = 4'b0010;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.out_valid", 64'(out_valid), 64'(0));
        check("abort.result", 64'(result), 64'(0));
        check("abort.in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort.no_late_valid", 64'(seen), 64'(0));
`ifdef ALU_SERIAL_CYCLE_CNT_EN
        exp_cnt = 0;
        check("abort.op_cnt", 64'(op_cnt), 64'(exp_cnt));
`endif

        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op($sformatf("rand%0d", n), ra, rb, ctrl_tbl[$urandom_range(0, 6)],
                   3'($urandom_range(0, 7)), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
